stopwatch_renderer: RTL and testbench

Clocked, parameterised successor to the combinational time drawer in the VGA path: renders `H:MM:SS:mmm` as seven-segment glyphs at a configurable position, size and colour. Time inputs are snapshotted once per frame and converted to BCD by a sequential divider, so digits never tear mid-frame. The pixel path is a fixed two-stage pipeline between the VGA timing generator and the colour mux.

---
 rtl/stopwatch_render_pkg.sv | 59 +++++
 rtl/div10_seq.sv | 34 +++
 rtl/stopwatch_renderer.sv | 208 ++++++++++++++++++++
 tb/tb_stopwatch_renderer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_render_pkg.sv
// rtl/stopwatch_render_pkg.sv - shared types, segment masks and cell layout for the stopwatch renderer
package stopwatch_render_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, DIV_MIN, DIV_SEC, DIV_MSH, DIV_MST, COMMIT
  } conv_state_e;

  typedef enum logic {
    CELL_DIGIT = 1'b0,
    CELL_COLON = 1'b1
  } cell_kind_e;

  localparam int NUM_CELLS  = 11;
  localparam int NUM_DIGITS = 8;

  // Layout H : M M : S S : m m m, left to right.
  function automatic cell_kind_e cell_kind(input int idx);
    case (idx)
      1, 4, 7: return CELL_COLON;
      default: return CELL_DIGIT;
    endcase
  endfunction

  function automatic int cell_width(input int idx, input int dw);
    return (cell_kind(idx) == CELL_COLON) ? dw / 2 : dw;
  endfunction

  function automatic int cell_start(input int idx, input int dw);
    int s;
    s = 0;
    for (int j = 0; j < idx; j++) s += cell_width(j, dw);
    return s;
  endfunction

  function automatic logic [2:0] digit_slot(input int idx);
    int n;
    n = 0;
    for (int j = 0; j < idx; j++) if (cell_kind(j) == CELL_DIGIT) n++;
    return 3'(n);
  endfunction

  // Bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_mask(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/div10_seq.sv
// rtl/div10_seq.sv - repeated-subtraction divider by 10 or 100, one subtract per cycle
module div10_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       div100,
  input  logic [9:0] dividend,
  output logic       done,
  output logic [3:0] quotient,
  output logic [9:0] remainder
);

  logic       use100;
  logic [9:0] divisor;

  assign divisor = use100 ? 10'd100 : 10'd10;
  assign done    = (remainder < divisor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder <= '0;
      quotient  <= '0;
      use100    <= 1'b0;
    end else if (start) begin
      remainder <= dividend;
      quotient  <= '0;
      use100    <= div100;
    end else if (!done) begin
      remainder <= remainder - divisor;
      quotient  <= quotient + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_renderer.sv
// rtl/stopwatch_renderer.sv - H:MM:SS:mmm seven-segment overlay with per-frame BCD snapshot
// Optional colon blinking with STOPWATCH_RENDERER_BLINK_EN.
module stopwatch_renderer #(
  parameter int         X0           = 125,
  parameter int         Y0           = 200,
  parameter int         DIGIT_WIDTH  = 32,
  parameter logic [2:0] COLOR        = 3'b010,
  parameter int         BLINK_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] row,
  input  logic [15:0] column,
  input  logic        frame_start,
  input  logic [3:0]  hours,
  input  logic [5:0]  minutes,
  input  logic [5:0]  seconds,
  input  logic [9:0]  milliseconds,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        busy
);
  import stopwatch_render_pkg::*;

  localparam int DW = DIGIT_WIDTH;
  localparam logic [15:0] X0_L   = 16'(X0);
  localparam logic [15:0] Y0_L   = 16'(Y0);
  localparam logic [15:0] W_L    = 16'(9 * DW + 3 * (DW / 2));
  localparam logic [15:0] DH_L   = 16'(2 * DW);
  localparam logic [15:0] HALF_L = 16'(DW);
  localparam logic [15:0] T_L    = 16'(DW / 8);
  localparam logic [15:0] GW_L   = 16'(DW - DW / 8);
  localparam logic [15:0] G0_L   = 16'(DW - DW / 16);
  localparam logic [15:0] CX0_L  = 16'(DW / 8);
  localparam logic [15:0] CX1_L  = 16'(3 * DW / 8);
  localparam logic [15:0] DOT1_L = 16'(DW / 2);
  localparam logic [15:0] DOT3_L = 16'(3 * DW / 2);

  conv_state_e state, state_nxt;
  logic        div_start, div_sel100, div_done;
  logic [9:0]  div_dividend, div_r;
  logic [3:0]  div_q;
  logic [3:0]  hours_s;
  logic [5:0]  min_s, sec_s;
  logic [9:0]  ms_s;
  logic [3:0]  work_d [NUM_DIGITS];
  logic [3:0]  disp_d [NUM_DIGITS];
  logic        colon_on;

  div10_seq u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .div100    (div_sel100),
    .dividend  (div_dividend),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The divider is loaded on the edge entering each stage, so a stage lasts quotient+1 cycles.
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_sel100   = 1'b0;
    div_dividend = '0;
    case (state)
      IDLE:    if (frame_start) state_nxt = LOAD;
      LOAD:    begin
        div_start    = 1'b1;
        div_dividend = {4'd0, min_s};
        state_nxt    = DIV_MIN;
      end
      DIV_MIN: if (div_done) begin
        div_start    = 1'b1;
        div_dividend = {4'd0, sec_s};
        state_nxt    = DIV_SEC;
      end
      DIV_SEC: if (div_done) begin
        div_start    = 1'b1;
        div_sel100   = 1'b1;
        div_dividend = ms_s;
        state_nxt    = DIV_MSH;
      end
      DIV_MSH: if (div_done) begin
        div_start    = 1'b1;
        div_dividend = div_r;
        state_nxt    = DIV_MST;
      end
      DIV_MST: if (div_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_s <= '0;
      min_s   <= '0;
      sec_s   <= '0;
      ms_s    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        work_d[i] <= '0;
        disp_d[i] <= '0;
      end
    end else begin
      if (state == IDLE && frame_start) begin
        hours_s <= (hours > 4'd9) ? 4'd9 : hours;
        min_s   <= (minutes > 6'd59) ? 6'd59 : minutes;
        sec_s   <= (seconds > 6'd59) ? 6'd59 : seconds;
        ms_s    <= (milliseconds > 10'd999) ? 10'd999 : milliseconds;
      end
      case (state)
        LOAD:    work_d[0] <= hours_s;
        DIV_MIN: if (div_done) begin work_d[1] <= div_q; work_d[2] <= div_r[3:0]; end
        DIV_SEC: if (div_done) begin work_d[3] <= div_q; work_d[4] <= div_r[3:0]; end
        DIV_MSH: if (div_done) work_d[5] <= div_q;
        DIV_MST: if (div_done) begin work_d[6] <= div_q; work_d[7] <= div_r[3:0]; end
        COMMIT:  for (int i = 0; i < NUM_DIGITS; i++) disp_d[i] <= work_d[i];
        default: ;
      endcase
    end
  end

`ifdef STOPWATCH_RENDERER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt <= '0;
    else if (frame_start)
      blink_cnt <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + BW'(1);
  end

  assign colon_on = (blink_cnt < BW'(BLINK_FRAMES / 2));
`else
  assign colon_on = 1'b1;
`endif

  logic        s1_in_box, s1_en;
  logic [15:0] s1_x, s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in_box <= 1'b0;
      s1_en     <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
    end else begin
      s1_in_box <= (column >= X0_L) && (column < X0_L + W_L) &&
                   (row >= Y0_L) && (row < Y0_L + DH_L);
      s1_en     <= enable;
      s1_x      <= column - X0_L;
      s1_y      <= row - Y0_L;
    end
  end

  logic        hit, in_gw, digit_px, colon_px, lit;
  cell_kind_e  hit_kind;
  logic [15:0] gx;
  logic [3:0]  hit_digit;
  logic [6:0]  seg_on;

  always_comb begin
    hit       = 1'b0;
    hit_kind  = CELL_DIGIT;
    gx        = '0;
    hit_digit = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (s1_x >= 16'(cell_start(i, DW)) &&
          s1_x <  16'(cell_start(i, DW) + cell_width(i, DW))) begin
        hit       = 1'b1;
        hit_kind  = cell_kind(i);
        gx        = s1_x - 16'(cell_start(i, DW));
        hit_digit = disp_d[digit_slot(i)];
      end
    end
    in_gw     = (gx < GW_L);
    seg_on[6] = in_gw && (s1_y < T_L);
    seg_on[5] = (gx >= GW_L - T_L) && in_gw && (s1_y < HALF_L);
    seg_on[4] = (gx >= GW_L - T_L) && in_gw && (s1_y >= HALF_L);
    seg_on[3] = in_gw && (s1_y >= DH_L - T_L);
    seg_on[2] = (gx < T_L) && (s1_y >= HALF_L);
    seg_on[1] = (gx < T_L) && (s1_y < HALF_L);
    seg_on[0] = in_gw && (s1_y >= G0_L) && (s1_y < G0_L + T_L);
    digit_px  = |(seg_mask(hit_digit) & seg_on);
    colon_px  = colon_on && (gx >= CX0_L) && (gx < CX1_L) &&
                (((s1_y >= DOT1_L - T_L) && (s1_y < DOT1_L + T_L)) ||
                 ((s1_y >= DOT3_L - T_L) && (s1_y < DOT3_L + T_L)));
    lit       = s1_en && s1_in_box && hit &&
                ((hit_kind == CELL_COLON) ? colon_px : digit_px);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {r, g, b} <= 3'b000;
    else        {r, g, b} <= lit ? COLOR : 3'b000;
  end

endmodule

// File: tb/tb_stopwatch_renderer.sv
// tb/tb_stopwatch_renderer.sv - randomized self-checking bench against a behavioural pixel model
module tb_stopwatch_renderer;

  localparam int X0 = 125;
  localparam int Y0 = 200;
  localparam int DW = 32;
  localparam int DH = 2 * DW;
  localparam int T  = DW / 8;
  localparam int GW = DW - DW / 8;
  localparam int W  = 9 * DW + 3 * (DW / 2);
  localparam int BF = 4;
  localparam logic [2:0] COLOR = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] row = '0;
  logic [15:0] column = '0;
  logic        frame_start = 1'b0;
  logic [3:0]  hours = '0;
  logic [5:0]  minutes = '0;
  logic [5:0]  seconds = '0;
  logic [9:0]  milliseconds = '0;
  logic        r, g, b, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int digits [8];
  int frames = 0;
  logic [2:0] pq [$];

  always #5 clk = ~clk;

  stopwatch_renderer #(
    .X0(X0), .Y0(Y0), .DIGIT_WIDTH(DW), .COLOR(COLOR), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .row(row), .column(column),
    .frame_start(frame_start), .hours(hours), .minutes(minutes), .seconds(seconds),
    .milliseconds(milliseconds), .r(r), .g(g), .b(b), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic string seg_str(input int d);
    case (d)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";
      3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
      6: return "acdefg";   7: return "abc";     8: return "abcdefg";
      default: return "abcdfg";
    endcase
  endfunction

  function automatic bit has_seg(input int d, input byte ch);
    string s;
    s = seg_str(d);
    for (int k = 0; k < s.len(); k++) if (s[k] == ch) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit glyph_lit(input int d, input int x, input int y);
    if (x >= GW) return 1'b0;
    if (y < T && has_seg(d, "a")) return 1'b1;
    if (x >= GW - T && y < DH / 2 && has_seg(d, "b")) return 1'b1;
    if (x >= GW - T && y >= DH / 2 && has_seg(d, "c")) return 1'b1;
    if (y >= DH - T && has_seg(d, "d")) return 1'b1;
    if (x < T && y >= DH / 2 && has_seg(d, "e")) return 1'b1;
    if (x < T && y < DH / 2 && has_seg(d, "f")) return 1'b1;
    if (y >= DH / 2 - T / 2 && y < DH / 2 - T / 2 + T && has_seg(d, "g")) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit colon_lit();
`ifdef STOPWATCH_RENDERER_BLINK_EN
    return (frames % BF) < BF / 2;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [2:0] model_px(input int rr, input int cc, input bit e);
    string layout;
    int x, y, pos, slot, w;
    layout = "DCDDCDDCDDD";
    x = cc - X0;
    y = rr - Y0;
    if (!e || x < 0 || x >= W || y < 0 || y >= DH) return 3'b000;
    pos = 0;
    slot = 0;
    for (int i = 0; i < layout.len(); i++) begin
      w = (layout[i] == "C") ? DW / 2 : DW;
      if (x < pos + w) begin
        x -= pos;
        if (layout[i] == "C")
          return (colon_lit() && x >= DW / 8 && x < 3 * DW / 8 &&
                  ((y >= DH / 4 - T && y < DH / 4 + T) ||
                   (y >= 3 * DH / 4 - T && y < 3 * DH / 4 + T))) ? COLOR : 3'b000;
        return glyph_lit(digits[slot], x, y) ? COLOR : 3'b000;
      end
      pos += w;
      if (layout[i] == "D") slot++;
    end
    return 3'b000;
  endfunction

  // One pixel per cycle; the output seen now belongs to the pixel driven two cycles ago.
  task automatic px(input int rr, input int cc, input bit e);
    @(posedge clk); #1;
    if (pq.size() == 2) check_eq("pixel", {r, g, b}, pq.pop_front());
    row = 16'(rr);
    column = 16'(cc);
    enable = e;
    pq.push_back(model_px(rr, cc, e));
  endtask

  task automatic drain();
    repeat (3) px(0, 0, 1'b0);
  endtask

  task automatic scan_rows();
    int ys [9] = '{-1, 0, 5, 14, 31, 33, 47, 63, 64};
    foreach (ys[k])
      for (int c = X0 - 2; c <= X0 + W + 1; c++) px(Y0 + ys[k], c, 1'b1);
    drain();
  endtask

  task automatic random_pixels(input int n);
    for (int k = 0; k < n; k++)
      px($urandom_range(Y0 + DH + 1, Y0 - 2), $urandom_range(X0 + W + 2, X0 - 3),
         bit'($urandom_range(3, 0) != 0));
    drain();
  endtask

  task automatic convert(input int h, input int m, input int s, input int ms, input bit dbl);
    int hc, mc, sc, msc, exp_len, cnt;
    hc  = (h > 9) ? 9 : h;
    mc  = (m > 59) ? 59 : m;
    sc  = (s > 59) ? 59 : s;
    msc = (ms > 999) ? 999 : ms;
    exp_len = 2 + (mc / 10 + 1) + (sc / 10 + 1) + (msc / 100 + 1) + ((msc % 100) / 10 + 1);
    hours = 4'(h); minutes = 6'(m); seconds = 6'(s); milliseconds = 10'(ms);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    frames++;
    hours = 4'($urandom); minutes = 6'($urandom);
    seconds = 6'($urandom); milliseconds = 10'($urandom);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      frame_start = dbl && exp_len > 11 && cnt == 10;
      if (frame_start) frames++;
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    check_eq("busy_len", cnt, exp_len);
    repeat (3) @(posedge clk);
    #1;
    check_eq("busy_after", busy, 1'b0);
    digits = '{hc, mc / 10, mc % 10, sc / 10, sc % 10, msc / 100, (msc / 10) % 10, msc % 10};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    digits = '{0, 0, 0, 0, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_rgb", {r, g, b}, 3'b000);
    rst_n = 1'b1;

    // Digit 0 after reset: top segment lit, with exact 2-cycle latency around the left edge.
    px(Y0 + 1, X0 + 1, 1'b1);
    px(Y0 + 1, X0, 1'b1);
    px(Y0 + 1, X0 - 1, 1'b1);
    px(Y0 + 1, X0, 1'b0);
    px(Y0 + 1, X0 + 1, 1'b1);
    drain();

    convert(3, 47, 5, 809, 1'b1);
    scan_rows();
    convert(12, 63, 61, 1023, 1'b0);
    scan_rows();

    // Reset in the middle of a conversion, with a lit colon pixel in flight.
    hours = 4'd7; minutes = 6'd30; seconds = 6'd30; milliseconds = 10'd500;
    row = 16'(Y0 + 14); column = 16'(X0 + DW + DW / 8); enable = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_rgb", {r, g, b}, 3'b000);
    @(posedge clk); #1;
    enable = 1'b0;
    rst_n = 1'b1;
    pq.delete();
    frames = 0;
    digits = '{0, 0, 0, 0, 0, 0, 0, 0};
    repeat (40) @(posedge clk);
    #1;
    check_eq("rst_idle_busy", busy, 1'b0);
    px(Y0 + 1, X0 + 1, 1'b1);
    px(Y0 + 1, X0 + 1, 1'b1);
    px(Y0 + 1, X0 + 1, 1'b1);
    drain();
    scan_rows();

    for (int it = 0; it < 5; it++) begin
      convert($urandom_range(15, 0), $urandom_range(63, 0), $urandom_range(63, 0),
              $urandom_range(1023, 0), bit'($urandom_range(1, 0)));
      scan_rows();
      random_pixels(200);
    end

`ifdef STOPWATCH_RENDERER_BLINK_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pq.delete();
    frames = 0;
    digits = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int f = 0; f < 8; f++) begin
      convert($urandom_range(9, 0), $urandom_range(59, 0), $urandom_range(59, 0),
              $urandom_range(999, 0), 1'b0);
      for (int c = X0 + DW; c < X0 + DW + DW / 2; c++) px(Y0 + 14, c, 1'b1);
      drain();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
